// File: rtl/load_store_unit.sv
// Data-memory load/store stage: runs one req/ack bus access per instruction and returns extended load data.
// Latency: 2 + n cycles, n = REQ cycles (1..TIMEOUT); misaligned or illegal accesses take 2 cycles.
// Backpressure: Stall holds the core until the access commits; the bus throttles us by withholding mem_ack.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    lat_off;
  logic [2:0]    lat_f3;

  logic          access;
  logic          misaligned;
  logic          f3_ok;
  logic          bad;
  logic          expired;
  logic [1:0]    off;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Decode the incoming instruction: legality, byte enables and lane-replicated store data.
  always_comb begin
    access     = MemRead | MemWrite;
    off        = ALUResult[1:0];
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    // A store with both strobes set is still a store, so MemWrite picks the legal funct3 set.
    if (MemWrite) begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
    bad       = misaligned | ~f3_ok;
    be_nxt    = 4'b1111;
    wdata_nxt = WriteData;
    if (MemWrite) begin
      case (funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << off;
          wdata_nxt = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << off;
          wdata_nxt = {2{WriteData[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = WriteData;
        end
      endcase
    end
    expired = (cnt == CNT_LAST);
  end

  // Align the returned word to the latched byte offset and extend it per the latched funct3.
  always_comb begin
    shifted = mem_rdata >> {lat_off, 3'b000};
    case (lat_f3)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and Stall; DONE drops Stall so the core commits while the same instruction is still present.
  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        Stall = access;
        if (access) state_nxt = bad ? DONE : REQ;
      end
      REQ: begin
        Stall = 1'b1;
        // An ack on the expiry cycle wins over the timeout.
        if (mem_ack || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) Stall = 1'b0;
  end

  // Bus outputs, latched access attributes, wait counter, load result and the one-cycle fault pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      ReadData  <= 32'h0;
      Fault     <= 1'b0;
      cnt       <= '0;
      lat_off   <= 2'b00;
      lat_f3    <= 3'b000;
    end else begin
      Fault <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access) begin
            lat_off <= off;
            lat_f3  <= funct3;
            if (bad) begin
              Fault    <= 1'b1;
              ReadData <= 32'h0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUResult[31:2], 2'b00};
              mem_be    <= be_nxt;
              mem_wdata <= wdata_nxt;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_be  <= 4'b0000;
            if (!mem_we) ReadData <= load_ext;
          end else if (expired) begin
            mem_req  <= 1'b0;
            mem_be   <= 4'b0000;
            Fault    <= 1'b1;
            ReadData <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus cycles and completions.
// A negedge monitor pops and compares on each new bus request and on each commit cycle.
// Bus acks are driven by the stimulus process at a per-vector REQ cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        chk_wdata;
  } bus_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        fault;
    int          stall;
    int          req;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int vec_id   = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (access %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
    end
  endtask

  // One access: push expectations, present the instruction, ack on REQ cycle ack_at (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdw,
                        input logic bus_exp, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_fault,
                        input int e_stall, input int e_req);
    bus_t  b;
    done_t d;
    int    cyc;
    vec_id++;
    if (bus_exp) begin
      b.id = vec_id; b.addr = e_addr; b.be = e_be; b.wdata = e_wdata;
      b.we = wr; b.chk_wdata = wr;
      bus_q.push_back(b);
    end
    d.id = vec_id; d.rdata = e_rdata; d.fault = e_fault; d.stall = e_stall; d.req = e_req;
    done_q.push_back(d);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd; mem_rdata = rdw;
    @(posedge clk); #1;
    cyc = 1;
    while (mem_req && cyc <= 64) begin
      mem_ack = (cyc == ack_at);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      cyc++;
    end
    if (mem_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus wait bound (access %0d): mem_req still 1 after %0d cycles, expected 0", vec_id, cyc);
    end
    // DONE cycle: the instruction is still presented and must be ignored.
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Monitor: compare bus requests and commits against the scoreboard queues.
  initial begin
    bit   prev_stall = 1'b0;
    bit   prev_req   = 1'b0;
    int   stall_cnt  = 0;
    int   req_cnt    = 0;
    bus_t  b;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
      end else begin
        if (Stall === 1'b1) stall_cnt++;
        if (mem_req === 1'b1) req_cnt++;
        if (mem_req === 1'b1 && !prev_req) begin
          if (bus_q.size() == 0) begin
            check("unexpected bus request", -1, 32'(mem_req), 32'h0);
          end else begin
            b = bus_q.pop_front();
            check("mem_addr", b.id, mem_addr, b.addr);
            check("mem_be", b.id, 32'(mem_be), 32'(b.be));
            check("mem_we", b.id, 32'(mem_we), 32'(b.we));
            if (b.chk_wdata) check("mem_wdata", b.id, mem_wdata, b.wdata);
          end
        end
        if (prev_stall && Stall === 1'b0) begin
          if (done_q.size() == 0) begin
            check("unexpected commit", -1, 32'(stall_cnt), 32'h0);
          end else begin
            d = done_q.pop_front();
            check("ReadData", d.id, ReadData, d.rdata);
            check("Fault", d.id, 32'(Fault), 32'(d.fault));
            check("stall cycles", d.id, 32'(stall_cnt), 32'(d.stall));
            check("mem_req cycles", d.id, 32'(req_cnt), 32'(d.req));
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end else begin
          check("Fault outside commit", -1, 32'(Fault), 32'h0);
        end
        prev_stall = (Stall === 1'b1);
        prev_req   = (mem_req === 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    rst_n = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
    ALUResult = 32'h0; WriteData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset Stall", -1, 32'(Stall), 32'h0);
    check("reset mem_req", -1, 32'(mem_req), 32'h0);
    check("reset mem_we", -1, 32'(mem_we), 32'h0);
    check("reset mem_be", -1, 32'(mem_be), 32'h0);
    check("reset mem_addr", -1, mem_addr, 32'h0);
    check("reset mem_wdata", -1, mem_wdata, 32'h0);
    check("reset ReadData", -1, ReadData, 32'h0);
    check("reset Fault", -1, 32'(Fault), 32'h0);
    rst_n = 1'b1; MemRead = 1'b0;

    // SB at offset 3 and offset 1.
    access(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCC5A, 1, 32'h0,
           1'b1, 32'h1000, 4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 1);
    access(1'b0, 1'b1, 3'b000, 32'h1001, 32'h00000077, 1, 32'h0,
           1'b1, 32'h1000, 4'b0010, 32'h77777777, 32'h0, 1'b0, 2, 1);
    // LB / LBU / LH at 0x2002, LH with two wait states.
    access(1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 1, 32'h12F45678,
           1'b1, 32'h2000, 4'b1111, 32'h0, 32'hFFFFFFF4, 1'b0, 2, 1);
    access(1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 1, 32'h12F45678,
           1'b1, 32'h2000, 4'b1111, 32'h0, 32'h000000F4, 1'b0, 2, 1);
    access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 3, 32'h12F45678,
           1'b1, 32'h2000, 4'b1111, 32'h0, 32'h000012F4, 1'b0, 4, 3);
    // SH at offset 2: ReadData untouched by a store.
    access(1'b0, 1'b1, 3'b001, 32'h2006, 32'h1234BEEF, 2, 32'h0,
           1'b1, 32'h2004, 4'b1100, 32'hBEEFBEEF, 32'h000012F4, 1'b0, 3, 2);
    // Misaligned LW: no bus cycle, Fault, ReadData cleared.
    access(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 1, 32'h0,
           1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    access(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 1, 32'hCAFEF00D,
           1'b1, 32'h3000, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1);
    // Illegal load funct3 011.
    access(1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 1, 32'h0,
           1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 1, 32'h8001ABCD,
           1'b1, 32'h2000, 4'b1111, 32'h0, 32'h00008001, 1'b0, 2, 1);
    // Illegal store funct3 100.
    access(1'b0, 1'b1, 3'b100, 32'h3000, 32'h11111111, 1, 32'h0,
           1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    access(1'b1, 1'b0, 3'b001, 32'h0000, 32'h0, 1, 32'h00008001,
           1'b1, 32'h0000, 4'b1111, 32'h0, 32'hFFFF8001, 1'b0, 2, 1);
    // Misaligned LHU.
    access(1'b1, 1'b0, 3'b101, 32'h2003, 32'h0, 1, 32'h0,
           1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    // MemRead and MemWrite together: treated as SW.
    access(1'b1, 1'b1, 3'b010, 32'h0044, 32'h01020304, 1, 32'hFFFFFFFF,
           1'b1, 32'h0044, 4'b1111, 32'h01020304, 32'h0, 1'b0, 2, 1);
    // Ack on the expiry cycle succeeds.
    access(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 4, 32'h87654321,
           1'b1, 32'h4000, 4'b1111, 32'h0, 32'h87654321, 1'b0, 5, 4);
    // No ack: timeout after 4 REQ cycles.
    access(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 0, 32'h55555555,
           1'b1, 32'h5000, 4'b1111, 32'h0, 32'h0, 1'b1, 5, 4);
    // Late ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late ack ReadData", -1, ReadData, 32'h0);
    check("late ack mem_req", -1, 32'(mem_req), 32'h0);
    check("late ack Stall", -1, 32'(Stall), 32'h0);

    // Reset in the second REQ cycle, with an ack on the reset edge.
    vec_id++;
    b.id = vec_id; b.addr = 32'h6000; b.be = 4'b1111; b.wdata = 32'h0; b.we = 1'b0; b.chk_wdata = 1'b0;
    bus_q.push_back(b);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h6000; mem_rdata = 32'h13572468;
    repeat (2) begin @(posedge clk); #1; end
    check("pre-reset mem_req", vec_id, 32'(mem_req), 32'h1);
    rst_n = 1'b0; MemRead = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("reset-in-REQ mem_req", vec_id, 32'(mem_req), 32'h0);
    check("reset-in-REQ mem_be", vec_id, 32'(mem_be), 32'h0);
    check("reset-in-REQ ReadData", vec_id, ReadData, 32'h0);
    check("reset-in-REQ Stall", vec_id, 32'(Stall), 32'h0);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 3'b010, 32'h0010, 32'hDEADBEEF, 1, 32'h0,
           1'b1, 32'h0010, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);

    repeat (3) begin @(posedge clk); #1; end
    check("pending bus expectations", -1, 32'(bus_q.size()), 32'h0);
    check("pending completions", -1, 32'(done_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
